// File: rtl/amdchipkill_pkg.sv
// Shared constants, payload types and GF(2^8) helpers for the (10,8) chipkill decoder.
package amdchipkill_pkg;

  localparam int unsigned SYM_W  = 8;
  localparam int unsigned N_SYM  = 10;
  localparam int unsigned N_DATA = 8;
  localparam int unsigned DATA_W = SYM_W * N_DATA;
  localparam int unsigned CW_W   = SYM_W * N_SYM;
  localparam int unsigned POS_W  = 4;
  localparam int unsigned CNT_W  = 4;

  // Field polynomial x^8+x^6+x^4+x^3+x^2+x+1
  localparam logic [SYM_W:0] GF_POLY = 9'h15F;

  localparam logic [POS_W-1:0] SYM_P0   = 4'd8;
  localparam logic [POS_W-1:0] SYM_P1   = 4'd9;
  localparam logic [POS_W-1:0] POS_NONE = 4'hF;

  typedef logic [SYM_W-1:0] gf_t;

  // Powers of alpha (0x02) for every H-matrix column that carries one
  localparam gf_t ALPHA_POW [0:N_SYM-1] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h5F, 8'hBE
  };

  typedef enum logic [1:0] {
    ST_NE  = 2'd0,
    ST_CE  = 2'd1,
    ST_DUE = 2'd2
  } status_e;

  // Stage-1 payload: raw data, syndromes and erasure information
  typedef struct packed {
    logic [DATA_W-1:0] data;
    gf_t               s0;
    gf_t               sy;
    logic [N_SYM-1:0]  mask;
    logic [CNT_W-1:0]  ecnt;
  } s1_t;

  // Stage-2 payload: erasure positions, inverted denominator, a^sel*S0
  typedef struct packed {
    logic [DATA_W-1:0] data;
    gf_t               s0;
    gf_t               sy;
    logic [CNT_W-1:0]  ecnt;
    logic [POS_W-1:0]  pos_i;
    logic [POS_W-1:0]  pos_j;
    gf_t               dinv;
    gf_t               asy;
  } s2_t;

  // GF(2^8) multiply, shift-and-add with modular reduction
  function automatic gf_t gf_mult(input gf_t a, input gf_t b);
    gf_t acc;
    gf_t sh;
    acc = '0;
    sh  = a;
    for (int n = 0; n < int'(SYM_W); n++) begin
      if (b[n]) acc = acc ^ sh;
      sh = sh[SYM_W-1] ? ({sh[SYM_W-2:0], 1'b0} ^ GF_POLY[SYM_W-1:0])
                       : {sh[SYM_W-2:0], 1'b0};
    end
    return acc;
  endfunction

  // alpha^idx for idx 0..9, zero for any other index
  function automatic gf_t alpha_pow(input logic [POS_W-1:0] idx);
    gf_t r;
    r = '0;
    for (int k = 0; k < int'(N_SYM); k++) begin
      if (idx == POS_W'(k)) r = ALPHA_POW[k];
    end
    return r;
  endfunction

  // Log table restricted to a^0..a^7; POS_NONE when x is not a data locator
  function automatic logic [POS_W-1:0] alpha_log(input gf_t x);
    logic [POS_W-1:0] r;
    r = POS_NONE;
    for (int k = 0; k < int'(N_DATA); k++) begin
      if (ALPHA_POW[k] == x) r = POS_W'(k);
    end
    return r;
  endfunction

  // XOR a value into data symbol idx; parity indices leave data untouched
  function automatic logic [DATA_W-1:0] sym_xor(input logic [DATA_W-1:0] d,
                                                input logic [POS_W-1:0]  idx,
                                                input gf_t               v);
    logic [DATA_W-1:0] r;
    r = d;
    for (int k = 0; k < int'(N_DATA); k++) begin
      if (idx == POS_W'(k)) r[DATA_W-1-SYM_W*k -: SYM_W] = r[DATA_W-1-SYM_W*k -: SYM_W] ^ v;
    end
    return r;
  endfunction

endpackage

// File: rtl/amdchipkill_gf_inv.sv
// Combinational GF(2^8) inverse as x^254 via a square-multiply chain; inv(0)=0.
module amdchipkill_gf_inv
  import amdchipkill_pkg::*;
(
  input  logic [SYM_W-1:0] x_i,
  output logic [SYM_W-1:0] inv_o
);

  gf_t x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;

  // 254 = 0b11111110: alternate squaring and multiply-by-x, final square
  always_comb begin
    x2    = gf_mult(x_i, x_i);
    x3    = gf_mult(x2, x_i);
    x6    = gf_mult(x3, x3);
    x7    = gf_mult(x6, x_i);
    x14   = gf_mult(x7, x7);
    x15   = gf_mult(x14, x_i);
    x30   = gf_mult(x15, x15);
    x31   = gf_mult(x30, x_i);
    x62   = gf_mult(x31, x31);
    x63   = gf_mult(x62, x_i);
    x126  = gf_mult(x63, x63);
    x127  = gf_mult(x126, x_i);
    inv_o = gf_mult(x127, x127);
  end

endmodule

// File: rtl/amdchipkill_decoder.sv
// Three-stage (10,8) chipkill RS decoder: syndromes, denominator inverse, correction.
module amdchipkill_decoder
  import amdchipkill_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   codeword_in,
  input  logic [N_SYM-1:0]  erasure_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        status_out,
  output logic [POS_W-1:0]  err_pos
);

  logic s1_v_q, s2_v_q;
  logic s1_ld_c, s2_ld_c, s3_ld_c;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  logic [POS_W-1:0] pos_i_c, pos_j_c, sel_c;
  gf_t              den_c, dinv_c, asy_c;

  logic              both_data_c, syn_zero_c;
  gf_t               prod_c;
  logic [POS_W-1:0]  lg_c;
  logic [DATA_W-1:0] data_d;
  status_e           st_d;
  logic [POS_W-1:0]  pos_d;

  // A stage loads when it is empty or its content moves on this cycle
  assign s3_ld_c  = !out_valid || out_ready;
  assign s2_ld_c  = !s2_v_q || s3_ld_c;
  assign s1_ld_c  = !s1_v_q || s2_ld_c;
  assign in_ready = s1_ld_c;

  // Stage 1: syndromes S0, Sy and erasure count
  always_comb begin
    s1_d      = '0;
    s1_d.data = codeword_in[CW_W-1 -: DATA_W];
    s1_d.mask = erasure_in;
    s1_d.s0   = codeword_in[2*SYM_W-1 -: SYM_W];
    s1_d.sy   = codeword_in[SYM_W-1:0];
    for (int k = 0; k < int'(N_DATA); k++) begin
      s1_d.s0 = s1_d.s0 ^ codeword_in[CW_W-1-SYM_W*k -: SYM_W];
      s1_d.sy = s1_d.sy ^ gf_mult(ALPHA_POW[k], codeword_in[CW_W-1-SYM_W*k -: SYM_W]);
    end
    for (int k = 0; k < int'(N_SYM); k++) begin
      s1_d.ecnt = s1_d.ecnt + CNT_W'(erasure_in[k]);
    end
  end

  // Stage-1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
    end else if (s1_ld_c) begin
      s1_v_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Stage 2: lowest and second-lowest erased positions
  always_comb begin
    pos_i_c = POS_NONE;
    pos_j_c = POS_NONE;
    for (int k = int'(N_SYM) - 1; k >= 0; k--) begin
      if (s1_q.mask[k]) pos_i_c = POS_W'(k);
    end
    for (int k = int'(N_SYM) - 1; k >= 0; k--) begin
      if (s1_q.mask[k] && (POS_W'(k) != pos_i_c)) pos_j_c = POS_W'(k);
    end
  end

  // Stage 2: denominator selection; zero where no division is needed
  always_comb begin
    den_c = '0;
    if (s1_q.ecnt == 4'd0) begin
      den_c = s1_q.s0;
    end else if ((s1_q.ecnt == 4'd2) && (pos_j_c < SYM_P0)) begin
      den_c = alpha_pow(pos_i_c) ^ alpha_pow(pos_j_c);
    end else if ((s1_q.ecnt == 4'd2) && (pos_j_c == SYM_P0)) begin
      den_c = alpha_pow(pos_i_c);
    end
  end

  // a^k*S0 for the single-erasure check, a^j*S0 for the two-data-erasure solve
  assign sel_c = (s1_q.ecnt == 4'd1) ? pos_i_c : pos_j_c;
  assign asy_c = gf_mult(alpha_pow(sel_c), s1_q.s0);

  amdchipkill_gf_inv u_gf_inv (
    .x_i   (den_c),
    .inv_o (dinv_c)
  );

  // Stage-2 payload assembly
  always_comb begin
    s2_d       = '0;
    s2_d.data  = s1_q.data;
    s2_d.s0    = s1_q.s0;
    s2_d.sy    = s1_q.sy;
    s2_d.ecnt  = s1_q.ecnt;
    s2_d.pos_i = pos_i_c;
    s2_d.pos_j = pos_j_c;
    s2_d.dinv  = dinv_c;
    s2_d.asy   = asy_c;
  end

  // Stage-2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      s2_q   <= '0;
    end else if (s2_ld_c) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) s2_q <= s2_d;
    end
  end

  // One shared multiplier: Sy*S0^-1 (locator), Sy*a^-i ({i,p0}) or two-data solve
  assign both_data_c = (s2_q.ecnt == 4'd2) && (s2_q.pos_j < SYM_P0);
  assign prod_c      = gf_mult(s2_q.sy ^ (both_data_c ? s2_q.asy : '0), s2_q.dinv);
  assign lg_c        = alpha_log(prod_c);
  assign syn_zero_c  = (s2_q.s0 == '0) && (s2_q.sy == '0);

  // Stage 3: error evaluation, correction and status
  always_comb begin
    data_d = s2_q.data;
    st_d   = ST_NE;
    pos_d  = POS_NONE;
    case (s2_q.ecnt)
      4'd0: begin
        if (syn_zero_c) begin
          st_d = ST_NE;
        end else if (s2_q.s0 == '0) begin
          st_d  = ST_CE;
          pos_d = SYM_P1;
        end else if (s2_q.sy == '0) begin
          st_d  = ST_CE;
          pos_d = SYM_P0;
        end else if (lg_c != POS_NONE) begin
          data_d = sym_xor(s2_q.data, lg_c, s2_q.s0);
          st_d   = ST_CE;
          pos_d  = lg_c;
        end else begin
          st_d = ST_DUE;
        end
      end
      4'd1: begin
        if (!syn_zero_c) begin
          st_d = ST_DUE;
          if ((s2_q.pos_i < SYM_P0) && (s2_q.sy == s2_q.asy)) begin
            data_d = sym_xor(s2_q.data, s2_q.pos_i, s2_q.s0);
            st_d   = ST_CE;
            pos_d  = s2_q.pos_i;
          end else if ((s2_q.pos_i == SYM_P0) && (s2_q.sy == '0)) begin
            st_d  = ST_CE;
            pos_d = SYM_P0;
          end else if ((s2_q.pos_i == SYM_P1) && (s2_q.s0 == '0)) begin
            st_d  = ST_CE;
            pos_d = SYM_P1;
          end
        end
      end
      4'd2: begin
        if (!syn_zero_c) st_d = ST_CE;
        if (both_data_c) begin
          data_d = sym_xor(sym_xor(s2_q.data, s2_q.pos_i, prod_c),
                           s2_q.pos_j, s2_q.s0 ^ prod_c);
        end else if ((s2_q.pos_i < SYM_P0) && (s2_q.pos_j == SYM_P0)) begin
          data_d = sym_xor(s2_q.data, s2_q.pos_i, prod_c);
        end else if ((s2_q.pos_i < SYM_P0) && (s2_q.pos_j == SYM_P1)) begin
          data_d = sym_xor(s2_q.data, s2_q.pos_i, s2_q.s0);
        end
      end
      default: begin
        st_d = ST_DUE;
      end
    endcase
  end

  // Output register; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      status_out <= ST_NE;
      err_pos    <= POS_NONE;
    end else if (s3_ld_c) begin
      out_valid <= s2_v_q;
      if (s2_v_q) begin
        data_out   <= data_d;
        status_out <= st_d;
        err_pos    <= pos_d;
      end
    end
  end

endmodule

// File: tb/tb_amdchipkill_decoder.sv
// Scoreboard bench for the chipkill decoder: directed syndromes, random loopback, backpressure, reset.
module tb_amdchipkill_decoder;

  localparam logic [1:0] NE  = 2'd0;
  localparam logic [1:0] CE  = 2'd1;
  localparam logic [1:0] DUE = 2'd2;
  localparam logic [3:0] PN  = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] codeword_in;
  logic [9:0]  erasure_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;
  logic [1:0]  status_out;
  logic [3:0]  err_pos;

  typedef struct {
    int          id;
    logic [63:0] data;
    logic [1:0]  st;
    logic [3:0]  pos;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          beat_id = 0;
  logic        bp_en = 1'b0;
  int          bp_cnt = 0;
  logic [3:0]  bp_pat = 4'b1001;
  logic [7:0]  apow [10];

  amdchipkill_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .codeword_in (codeword_in),
    .erasure_in  (erasure_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .status_out  (status_out),
    .err_pos     (err_pos)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ s;
      s = s[7] ? ({s[6:0], 1'b0} ^ 8'h5F) : {s[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [79:0] encode(input logic [63:0] d);
    logic [7:0] p0;
    logic [7:0] p1;
    logic [7:0] s;
    p0 = 8'h00;
    p1 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      s  = d[63-8*k -: 8];
      p0 = p0 ^ s;
      p1 = p1 ^ gmul(apow[k], s);
    end
    return {d, p0, p1};
  endfunction

  function automatic logic [79:0] flip(input logic [79:0] cw, input int k, input logic [7:0] e);
    logic [79:0] r;
    r = cw;
    r[79-8*k -: 8] = r[79-8*k -: 8] ^ e;
    return r;
  endfunction

  function automatic exp_t mk(input logic [63:0] d, input logic [1:0] st, input logic [3:0] pos);
    exp_t e;
    e.id   = 0;
    e.data = d;
    e.st   = st;
    e.pos  = pos;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_en) begin
      out_ready = bp_pat[bp_cnt % 4];
      bp_cnt++;
    end
  endtask

  // Drive one beat until accepted, then record its expected result
  task automatic send(input logic [79:0] cw, input logic [9:0] m, input exp_t e);
    logic done;
    int   n;
    done        = 1'b0;
    n           = 0;
    in_valid    = 1'b1;
    codeword_in = cw;
    erasure_in  = m;
    while (!done && n < 100) begin
      @(negedge clk);
      done = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (done) begin
      e.id = beat_id;
      beat_id++;
      q.push_back(e);
    end else begin
      chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(q.size()), 64'd0);
  endtask

  // Output monitor: every valid output cycle is compared against the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          chk($sformatf("data#%0d", q[0].id), data_out, q[0].data);
          chk($sformatf("status#%0d", q[0].id), 64'(status_out), 64'(q[0].st));
          chk($sformatf("err_pos#%0d", q[0].id), 64'(err_pos), 64'(q[0].pos));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] cw;
    logic [63:0] d;
    logic [9:0]  m;
    logic [7:0]  ei;
    logic [7:0]  ej;
    int          i;
    int          j;
    int          n;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    codeword_in = '0;
    erasure_in  = '0;
    out_ready   = 1'b1;
    apow[0]     = 8'h01;
    for (int k = 1; k < 10; k++) apow[k] = gmul(apow[k-1], 8'h02);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_status", 64'(status_out), 64'(NE));
    chk("rst_err_pos", 64'(err_pos), 64'(PN));
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // Latency: output valid two edges after the accepting edge
    send(80'd0, 10'd0, mk(64'd0, NE, PN));
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("latency_edges", 64'(n), 64'd2);
    drain();

    // Single data-symbol error, no erasures
    cw = '0;
    cw[55:48] = 8'h5A;
    send(cw, 10'd0, mk(64'd0, CE, 4'd3));
    // Locator a^8 is not a data column
    cw = '0;
    cw[79:72] = 8'h01;
    cw[7:0]   = 8'h5E;
    send(cw, 10'd0, mk(cw[79:16], DUE, PN));
    // Two data erasures
    cw = '0;
    cw[63:56] = 8'h11;
    cw[39:32] = 8'h22;
    send(cw, 10'b0000100100, mk(64'd0, CE, PN));
    send(cw, 10'b0000101100, mk(cw[79:16], DUE, PN));
    // Erasure at the wrong symbol vs the right one
    cw = '0;
    cw[31:24] = 8'h33;
    send(cw, 10'b0000010000, mk(cw[79:16], DUE, PN));
    send(cw, 10'b0001000000, mk(64'd0, CE, 4'd6));
    // Parity-only errors
    cw = '0;
    cw[15:8] = 8'hA7;
    send(cw, 10'd0, mk(64'd0, CE, 4'd8));
    cw = '0;
    cw[7:0] = 8'h3C;
    send(cw, 10'd0, mk(64'd0, CE, 4'd9));
    drain();

    // Encoder loopback, clean codewords
    for (int t = 0; t < 1000; t++) begin
      d = {$urandom(), $urandom()};
      send(encode(d), 10'd0, mk(d, NE, PN));
    end
    drain();

    // Random single-symbol errors without erasures
    for (int t = 0; t < 60; t++) begin
      d  = {$urandom(), $urandom()};
      i  = int'($urandom_range(9, 0));
      ei = 8'($urandom_range(255, 1));
      send(flip(encode(d), i, ei), 10'd0, mk(d, CE, 4'(i)));
    end
    // Random single erasures carrying a nonzero error
    for (int t = 0; t < 30; t++) begin
      d  = {$urandom(), $urandom()};
      i  = int'($urandom_range(9, 0));
      ei = 8'($urandom_range(255, 1));
      m  = '0;
      m[i] = 1'b1;
      send(flip(encode(d), i, ei), m, mk(d, CE, 4'(i)));
    end
    // Random erasure pairs, error values may be zero
    for (int t = 0; t < 60; t++) begin
      d  = {$urandom(), $urandom()};
      i  = int'($urandom_range(8, 0));
      j  = int'($urandom_range(9, i + 1));
      ei = (t % 7 == 0) ? 8'h00 : 8'($urandom_range(255, 0));
      ej = (t % 7 == 0) ? 8'h00 : 8'($urandom_range(255, 0));
      m  = '0;
      m[i] = 1'b1;
      m[j] = 1'b1;
      cw = flip(flip(encode(d), i, ei), j, ej);
      send(cw, m, mk(d, (ei == 8'h00 && ej == 8'h00) ? NE : CE, PN));
    end
    drain();

    // Backpressure: out_ready cycles 1-0-0-1 while 8 beats stream
    bp_en  = 1'b1;
    bp_cnt = 0;
    for (int t = 0; t < 8; t++) begin
      d  = {$urandom(), $urandom()};
      i  = t % 8;
      ei = 8'(t + 1);
      send(flip(encode(d), i, ei), 10'd0, mk(d, CE, 4'(i)));
    end
    drain();
    bp_en     = 1'b0;
    out_ready = 1'b1;
    tick();

    // Reset with three beats in flight
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) send(80'd0, 10'd0, mk(64'd0, NE, PN));
    chk("inflight_out_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_err_pos", 64'(err_pos), 64'(PN));
    q.delete();
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("post_reset_idle", {63'd0, out_valid}, 64'd0);

    // Recovery after reset
    cw = '0;
    cw[71:64] = 8'hC3;
    send(cw, 10'd0, mk(64'd0, CE, 4'd1));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
